// File: rtl/seq_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle through a ripple stage with a
// registered carry, valid/ready handshakes on both sides, results held until consumed.
module seq_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             r_inReady;
  logic             r_outValid;
  logic             r_busy;

  logic [CHUNK-1:0] w_s;
  logic             w_c;
  logic             w_cMsb;
  logic [WIDTH-1:0] w_resNext;

  // Operands shift right each cycle so the active chunk always sits in the low bits;
  // finished chunks enter the result from the top and land in place after N shifts.
  assign {w_c, w_s} = {1'b0, r_opA[CHUNK-1:0]} + {1'b0, r_opB[CHUNK-1:0]}
                    + (CHUNK+1)'(r_carry);
  assign w_cMsb     = w_s[CHUNK-1] ^ r_opA[CHUNK-1] ^ r_opB[CHUNK-1];
  assign w_resNext  = (r_res >> CHUNK) | (WIDTH'(w_s) << (WIDTH - CHUNK));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_opA      <= '0;
      r_opB      <= '0;
      r_res      <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
      r_carry    <= 1'b0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA     <= a;
            r_opB     <= sub ? ~b : b;
            r_carry   <= sub;
            r_cnt     <= '0;
            r_inReady <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_opA   <= r_opA >> CHUNK;
          r_opB   <= r_opB >> CHUNK;
          r_res   <= w_resNext;
          r_carry <= w_c;
          if (r_cnt == LAST) begin
            r_sum      <= w_resNext;
            r_cout     <= w_c;
            r_ovf      <= w_cMsb ^ w_c;
            r_cnt      <= '0;
            r_outValid <= 1'b1;
            r_state    <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          // A new request seen on the handshake edge waits for the following IDLE cycle.
          if (out_ready) begin
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_state    <= IDLE;
          r_inReady  <= 1'b1;
          r_outValid <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign busy      = r_busy;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_adder.sv
// Bench for seq_adder: directed boundaries, backpressure, reset mid-operation and a
// randomized sweep of four WIDTH/CHUNK configurations against an arithmetic model.
module tb_seq_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        inValid  [4];
  logic [31:0] opA      [4];
  logic [31:0] opB      [4];
  logic        opSub    [4];
  logic        outReady [4];
  logic        inReady  [4];
  logic        outValid [4];
  logic        coutO    [4];
  logic        ovfO     [4];
  logic        busyO    [4];
  logic [15:0] sum16    [3];
  logic [31:0] sum32;

  int compared   = 0;
  int mismatched = 0;

  seq_adder #(.WIDTH(16), .CHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(opA[0][15:0]), .b(opB[0][15:0]), .sub(opSub[0]), .out_valid(outValid[0]),
    .out_ready(outReady[0]), .sum(sum16[0]), .cout(coutO[0]), .ovf(ovfO[0]), .busy(busyO[0]));

  seq_adder #(.WIDTH(16), .CHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(opA[1][15:0]), .b(opB[1][15:0]), .sub(opSub[1]), .out_valid(outValid[1]),
    .out_ready(outReady[1]), .sum(sum16[1]), .cout(coutO[1]), .ovf(ovfO[1]), .busy(busyO[1]));

  seq_adder #(.WIDTH(16), .CHUNK(16)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(opA[2][15:0]), .b(opB[2][15:0]), .sub(opSub[2]), .out_valid(outValid[2]),
    .out_ready(outReady[2]), .sum(sum16[2]), .cout(coutO[2]), .ovf(ovfO[2]), .busy(busyO[2]));

  seq_adder #(.WIDTH(32), .CHUNK(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid[3]), .in_ready(inReady[3]),
    .a(opA[3]), .b(opB[3]), .sub(opSub[3]), .out_valid(outValid[3]),
    .out_ready(outReady[3]), .sum(sum32), .cout(coutO[3]), .ovf(ovfO[3]), .busy(busyO[3]));

  function automatic int widthOf(input int cfg);
    return (cfg == 3) ? 32 : 16;
  endfunction

  // Expected latency in cycles, WIDTH/CHUNK for each instance.
  function automatic int latOf(input int cfg);
    case (cfg)
      0:       return 4;
      1:       return 16;
      2:       return 1;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] sumOf(input int cfg);
    if (cfg == 3) return sum32;
    return {16'h0000, sum16[cfg]};
  endfunction

  // Reference: plain integer add/subtract, unsigned compare for the borrow, sign rules for overflow.
  function automatic logic [33:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                        input logic s);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] r;
    logic        c;
    logic        sa;
    logic        sb;
    logic        sr;
    logic        o;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (!s) begin
      full = {1'b0, x} + {1'b0, y};
      r    = full[31:0] & mask;
      c    = full[w];
    end else begin
      full = '0;
      r    = (x - y) & mask;
      c    = (x >= y);
    end
    sa = x[w-1];
    sb = y[w-1];
    sr = r[w-1];
    o  = s ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {o, c, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one operand pair, then wait (bounded) for out_valid; lat counts edges after accept.
  task automatic runOp(input int cfg, input logic [31:0] x, input logic [31:0] y,
                       input logic s, output int lat, output bit ok);
    int guard;
    ok    = 1'b1;
    lat   = 0;
    guard = 0;
    while (!inReady[cfg] && guard < 200) begin
      tick();
      guard++;
    end
    if (!inReady[cfg]) begin
      ok = 1'b0;
      return;
    end
    opA[cfg]     = x;
    opB[cfg]     = y;
    opSub[cfg]   = s;
    inValid[cfg] = 1'b1;
    tick();
    inValid[cfg] = 1'b0;
    while (!outValid[cfg] && lat < 200) begin
      tick();
      lat++;
    end
    if (!outValid[cfg]) ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    for (int c = 0; c < 4; c++) begin
      compared++;
      if (inReady[c] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL reset_in_ready cfg%0d: got %b want 1", c, inReady[c]);
      end
      compared++;
      if (outValid[c] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_out_valid cfg%0d: got %b want 0", c, outValid[c]);
      end
      compared++;
      if (busyO[c] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_busy cfg%0d: got %b want 0", c, busyO[c]);
      end
      compared++;
      if (sumOf(c) !== 32'h0 || coutO[c] !== 1'b0 || ovfO[c] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_result cfg%0d: got sum=%h cout=%b ovf=%b want 0/0/0",
                 c, sumOf(c), coutO[c], ovfO[c]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add_sub();
    logic [15:0] ta [6];
    logic [15:0] tbv[6];
    logic        ts [6];
    logic [15:0] es [6];
    logic        ec [6];
    logic        eo [6];
    int          lat;
    bit          ok;
    ta  = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000, 16'h0007};
    tbv = '{16'h0FFF, 16'h0001, 16'h0001, 16'h0007, 16'h0001, 16'h0007};
    ts  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    es  = '{16'h2233, 16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF, 16'h0000};
    ec  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    eo  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      runOp(0, {16'h0, ta[i]}, {16'h0, tbv[i]}, ts[i], lat, ok);
      compared++;
      if (!ok || lat != 4) begin
        mismatched++;
        $display("[TB] FAIL directed_latency #%0d: got %0d (ok=%0d) want 4", i, lat, ok);
      end
      compared++;
      if (sum16[0] !== es[i] || coutO[0] !== ec[i] || ovfO[0] !== eo[i]) begin
        mismatched++;
        $display("[TB] FAIL directed_result #%0d: got sum=%h cout=%b ovf=%b want %h/%b/%b",
                 i, sum16[0], coutO[0], ovfO[0], es[i], ec[i], eo[i]);
      end
      compared++;
      if (busyO[0] !== 1'b1 || inReady[0] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL done_flags #%0d: got busy=%b in_ready=%b want 1/0",
                 i, busyO[0], inReady[0]);
      end
      tick();
      compared++;
      if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL one_cycle_valid #%0d: got out_valid=%b in_ready=%b want 0/1",
                 i, outValid[0], inReady[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit ok;
    outReady[0] = 1'b0;
    runOp(0, 32'h0000_ABCD, 32'h0000_1111, 1'b0, lat, ok);
    compared++;
    if (!ok || sum16[0] !== 16'hBCDE || coutO[0] !== 1'b0 || ovfO[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_first_result: got ok=%0d sum=%h cout=%b ovf=%b want BCDE/0/0",
               ok, sum16[0], coutO[0], ovfO[0]);
    end
    opA[0]     = 32'h0000_4000;
    opB[0]     = 32'h0000_4000;
    opSub[0]   = 1'b0;
    inValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      compared++;
      if (sum16[0] !== 16'hBCDE || coutO[0] !== 1'b0 || ovfO[0] !== 1'b0 ||
          outValid[0] !== 1'b1 || inReady[0] !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL bp_hold cycle %0d: got sum=%h c=%b o=%b v=%b rdy=%b want BCDE/0/0/1/0",
                 i, sum16[0], coutO[0], ovfO[0], outValid[0], inReady[0]);
      end
    end
    outReady[0] = 1'b1;
    tick();
    compared++;
    if (outValid[0] !== 1'b0 || inReady[0] !== 1'b1 || busyO[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_release: got v=%b rdy=%b busy=%b want 0/1/0",
               outValid[0], inReady[0], busyO[0]);
    end
    tick();
    inValid[0] = 1'b0;
    compared++;
    if (inReady[0] !== 1'b0 || busyO[0] !== 1'b1 || sum16[0] !== 16'hBCDE) begin
      mismatched++;
      $display("[TB] FAIL bp_accept: got rdy=%b busy=%b sum=%h want 0/1/BCDE",
               inReady[0], busyO[0], sum16[0]);
    end
    lat = 0;
    while (!outValid[0] && lat < 200) begin
      tick();
      lat++;
    end
    compared++;
    if (lat != 4 || sum16[0] !== 16'h8000 || coutO[0] !== 1'b0 || ovfO[0] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_second_result: got lat=%0d sum=%h cout=%b ovf=%b want 4/8000/0/1",
               lat, sum16[0], coutO[0], ovfO[0]);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit ok;
    bit sawValid;
    opA[0]     = 32'h0000_00FF;
    opB[0]     = 32'h0000_0F01;
    opSub[0]   = 1'b0;
    inValid[0] = 1'b1;
    tick();
    inValid[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    compared++;
    if (inReady[0] !== 1'b1 || busyO[0] !== 1'b0 || outValid[0] !== 1'b0 ||
        sum16[0] !== 16'h0 || coutO[0] !== 1'b0 || ovfO[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_state: got rdy=%b busy=%b v=%b sum=%h c=%b o=%b want 1/0/0/0/0/0",
               inReady[0], busyO[0], outValid[0], sum16[0], coutO[0], ovfO[0]);
    end
    sawValid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (outValid[0] === 1'b1) sawValid = 1'b1;
    end
    compared++;
    if (sawValid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_no_result: got out_valid seen=%b want 0", sawValid);
    end
    rst_n = 1'b1;
    runOp(0, 32'h0000_0001, 32'h0000_0001, 1'b0, lat, ok);
    compared++;
    if (!ok || lat != 4 || sum16[0] !== 16'h0002 || coutO[0] !== 1'b0 || ovfO[0] !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL post_reset_op: got ok=%0d lat=%0d sum=%h c=%b o=%b want 1/4/0002/0/0",
               ok, lat, sum16[0], coutO[0], ovfO[0]);
    end
    tick();
  endtask

  task automatic test_sweep(input int cfg, input int count);
    logic [31:0] mask;
    logic [31:0] x;
    logic [31:0] y;
    logic        s;
    logic [33:0] exp;
    int          lat;
    bit          ok;
    mask = (widthOf(cfg) == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    for (int i = 0; i < count; i++) begin
      x   = $urandom & mask;
      y   = $urandom & mask;
      s   = 1'($urandom_range(0, 1));
      exp = model(widthOf(cfg), x, y, s);
      runOp(cfg, x, y, s, lat, ok);
      compared++;
      if (!ok || lat != latOf(cfg)) begin
        mismatched++;
        $display("[TB] FAIL sweep_latency cfg%0d #%0d: got %0d (ok=%0d) want %0d",
                 cfg, i, lat, ok, latOf(cfg));
      end
      compared++;
      if (sumOf(cfg) !== exp[31:0]) begin
        mismatched++;
        $display("[TB] FAIL sweep_sum cfg%0d #%0d a=%h b=%h sub=%b: got %h want %h",
                 cfg, i, x, y, s, sumOf(cfg), exp[31:0]);
      end
      compared++;
      if (coutO[cfg] !== exp[32]) begin
        mismatched++;
        $display("[TB] FAIL sweep_cout cfg%0d #%0d a=%h b=%h sub=%b: got %b want %b",
                 cfg, i, x, y, s, coutO[cfg], exp[32]);
      end
      compared++;
      if (ovfO[cfg] !== exp[33]) begin
        mismatched++;
        $display("[TB] FAIL sweep_ovf cfg%0d #%0d a=%h b=%h sub=%b: got %b want %b",
                 cfg, i, x, y, s, ovfO[cfg], exp[33]);
      end
      tick();
    end
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      inValid[c]  = 1'b0;
      opA[c]      = '0;
      opB[c]      = '0;
      opSub[c]    = 1'b0;
      outReady[c] = 1'b1;
    end
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid();
    test_sweep(0, 1000);
    test_sweep(1, 1000);
    test_sweep(2, 1000);
    test_sweep(3, 1000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
